// File: rtl/barrel_shifter_rotator_if.sv
// Operand/result bundle for barrel_shifter_rotator; slave is the shifter side,
// master is whoever drives the operand and consumes the results.
interface barrel_shifter_rotator_if #(
    parameter int N = 8
);
    localparam int SA_W = $clog2(N);

    logic [N-1:0]    data_i;
    logic [SA_W-1:0] shift_amount_i;
    logic            shift_direction_i;
    logic            valid_i;
    logic [N-1:0]    shifted_data_o;
    logic [N-1:0]    shifted_data_q_o;
    logic            valid_o;

    modport slave (
        input  data_i,
        input  shift_amount_i,
        input  shift_direction_i,
        input  valid_i,
        output shifted_data_o,
        output shifted_data_q_o,
        output valid_o
    );

    modport master (
        output data_i,
        output shift_amount_i,
        output shift_direction_i,
        output valid_i,
        input  shifted_data_o,
        input  shifted_data_q_o,
        input  valid_o
    );
endinterface

// File: rtl/barrel_shifter_rotator.sv
// N-bit rotating barrel shifter: log2(N)-stage right-rotate mux network, combinational
// and registered outputs. Define BARREL_SHIFTER_PIPE_EN for a 2-cycle registered path.
module barrel_shifter_rotator #(
    parameter int N = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    barrel_shifter_rotator_if.slave bus
);
    localparam int SA_W = $clog2(N);

    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("barrel_shifter_rotator: N must be a power of two and >= 2");
    end

    function automatic logic [N-1:0] bit_reverse(input logic [N-1:0] x);
        logic [N-1:0] y;
        for (int k = 0; k < N; k++) begin
            y[k] = x[N-1-k];
        end
        return y;
    endfunction

    // Left rotate = reverse, rotate right, reverse; one right-rotate network serves both.
    logic [N-1:0] w_stage [SA_W+1];
    logic [N-1:0] w_result;

    assign w_stage[0] = bus.shift_direction_i ? bit_reverse(bus.data_i) : bus.data_i;

    for (genvar j = 0; j < SA_W; j++) begin : g_stage
        localparam int SH = 1 << j;
        assign w_stage[j+1] = bus.shift_amount_i[j]
                            ? {w_stage[j][SH-1:0], w_stage[j][N-1:SH]}
                            : w_stage[j];
    end

    assign w_result           = bus.shift_direction_i ? bit_reverse(w_stage[SA_W]) : w_stage[SA_W];
    assign bus.shifted_data_o = w_result;

    logic [N-1:0] r_data_q;
    logic         r_valid_q;

`ifdef BARREL_SHIFTER_PIPE_EN
    localparam int P = SA_W / 2;

    logic [N-1:0]    r_mid_data;
    logic [SA_W-1:P] r_mid_sa;
    logic            r_mid_dir;
    logic            r_mid_valid;
    logic [N-1:0]    w_tail [P:SA_W];
    logic [N-1:0]    w_tail_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mid_data  <= '0;
            r_mid_sa    <= '0;
            r_mid_dir   <= 1'b0;
            r_mid_valid <= 1'b0;
        end else begin
            r_mid_valid <= bus.valid_i;
            if (bus.valid_i) begin
                r_mid_data <= w_stage[P];
                r_mid_sa   <= bus.shift_amount_i[SA_W-1:P];
                r_mid_dir  <= bus.shift_direction_i;
            end
        end
    end

    // Second half of the network re-built on the registered mid-point.
    assign w_tail[P] = r_mid_data;

    for (genvar j = P; j < SA_W; j++) begin : g_tail
        localparam int SH = 1 << j;
        assign w_tail[j+1] = r_mid_sa[j]
                           ? {w_tail[j][SH-1:0], w_tail[j][N-1:SH]}
                           : w_tail[j];
    end

    assign w_tail_result = r_mid_dir ? bit_reverse(w_tail[SA_W]) : w_tail[SA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_valid_q <= r_mid_valid;
            if (r_mid_valid) begin
                r_data_q <= w_tail_result;
            end
        end
    end
`else
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_valid_q <= bus.valid_i;
            if (bus.valid_i) begin
                r_data_q <= w_result;
            end
        end
    end
`endif

    assign bus.shifted_data_q_o = r_data_q;
    assign bus.valid_o          = r_valid_q;
endmodule

// File: tb/tb_barrel_shifter_rotator.sv
// Self-checking bench for barrel_shifter_rotator: directed and random rotates at
// N = 2/8/16/32 against a modulo-index model, plus a queue model of the registered path.
module tb_barrel_shifter_rotator;
`ifdef BARREL_SHIFTER_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    barrel_shifter_rotator_if #(.N(2))  bus2 ();
    barrel_shifter_rotator_if #(.N(8))  bus8 ();
    barrel_shifter_rotator_if #(.N(16)) bus16 ();
    barrel_shifter_rotator_if #(.N(32)) bus32 ();

    barrel_shifter_rotator #(.N(2))  u_dut2  (.clk(clk), .rst(rst), .bus(bus2));
    barrel_shifter_rotator #(.N(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
    barrel_shifter_rotator #(.N(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
    barrel_shifter_rotator #(.N(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: out[k] = d[(k + s) mod n] for right, d[(k - s) mod n] for left.
    function automatic logic [31:0] ref_rot(input int n, input logic [31:0] d,
                                            input int s, input logic dir);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < n; k++) begin
            int idx;
            idx  = dir ? ((((k - s) % n) + n) % n) : ((k + s) % n);
            r[k] = d[idx];
        end
        return r;
    endfunction

    typedef struct {
        logic       v;
        logic [7:0] d;
    } pipe_entry_t;

    pipe_entry_t hist[$];
    logic [7:0]  exp_q = '0;

    task automatic reset_model();
        hist.delete();
        exp_q = '0;
    endtask

    // One clock of the N=8 registered path: drive, edge, then compare against the queue model.
    task automatic step8(input logic [7:0] d, input logic [2:0] s, input logic dir, input logic v);
        pipe_entry_t e;
        logic [31:0] r;
        logic        ev;
        bus8.data_i            = d;
        bus8.shift_amount_i    = s;
        bus8.shift_direction_i = dir;
        bus8.valid_i           = v;
        @(posedge clk);
        r   = ref_rot(8, {24'b0, d}, int'(s), dir);
        e.v = v;
        e.d = r[7:0];
        hist.push_back(e);
        while (hist.size() > LAT) void'(hist.pop_front());
        ev = 1'b0;
        if (hist.size() == LAT) begin
            ev = hist[0].v;
            if (hist[0].v) exp_q = hist[0].d;
        end
        #1;
        check("valid_o", {31'b0, bus8.valid_o}, {31'b0, ev});
        check("q_data", {24'b0, bus8.shifted_data_q_o}, {24'b0, exp_q});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  dir_r [8];
        logic [7:0]  dir_l [8];
        logic [1:0]  d2;
        logic [7:0]  d8;
        logic [15:0] d16;
        logic [31:0] d32;
        int          s2, s8, s16, s32;
        logic        dr2, dr8, dr16, dr32;
        logic [7:0]  last_in;
        logic [31:0] last_exp;

        dir_r = '{8'hF0, 8'h78, 8'h3C, 8'h1E, 8'h0F, 8'h87, 8'hC3, 8'hE1};
        dir_l = '{8'hF0, 8'hE1, 8'hC3, 8'h87, 8'h0F, 8'h1E, 8'h3C, 8'h78};

        bus2.data_i  = '0; bus2.shift_amount_i  = '0; bus2.shift_direction_i  = 1'b0; bus2.valid_i  = 1'b0;
        bus8.data_i  = '0; bus8.shift_amount_i  = '0; bus8.shift_direction_i  = 1'b0; bus8.valid_i  = 1'b0;
        bus16.data_i = '0; bus16.shift_amount_i = '0; bus16.shift_direction_i = 1'b0; bus16.valid_i = 1'b0;
        bus32.data_i = '0; bus32.shift_amount_i = '0; bus32.shift_direction_i = 1'b0; bus32.valid_i = 1'b0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_q", {24'b0, bus8.shifted_data_q_o}, 32'h0);
        check("reset_valid", {31'b0, bus8.valid_o}, 32'h0);

        // Combinational path must work regardless of rst.
        bus8.data_i         = 8'hF0;
        bus8.shift_amount_i = 3'd1;
        #1;
        check("comb_in_reset", {24'b0, bus8.shifted_data_o}, 32'h78);

        rst = 1'b0;
        reset_model();

        for (int s = 0; s < 8; s++) begin
            bus8.shift_direction_i = 1'b0;
            bus8.shift_amount_i    = 3'(s);
            #1;
            check($sformatf("dir_right_s%0d", s), {24'b0, bus8.shifted_data_o}, {24'b0, dir_r[s]});
        end
        for (int s = 0; s < 8; s++) begin
            bus8.shift_direction_i = 1'b1;
            bus8.shift_amount_i    = 3'(s);
            #1;
            check($sformatf("dir_left_s%0d", s), {24'b0, bus8.shifted_data_o}, {24'b0, dir_l[s]});
        end

        // 250 iterations x 4 widths = 1000 random vectors.
        for (int i = 0; i < 250; i++) begin
            d2  = 2'($urandom);  s2  = $urandom_range(1, 0);  dr2  = 1'($urandom);
            d8  = 8'($urandom);  s8  = $urandom_range(7, 0);  dr8  = 1'($urandom);
            d16 = 16'($urandom); s16 = $urandom_range(15, 0); dr16 = 1'($urandom);
            d32 = $urandom;      s32 = $urandom_range(31, 0); dr32 = 1'($urandom);
            bus2.data_i  = d2;  bus2.shift_amount_i  = 1'(s2);  bus2.shift_direction_i  = dr2;
            bus8.data_i  = d8;  bus8.shift_amount_i  = 3'(s8);  bus8.shift_direction_i  = dr8;
            bus16.data_i = d16; bus16.shift_amount_i = 4'(s16); bus16.shift_direction_i = dr16;
            bus32.data_i = d32; bus32.shift_amount_i = 5'(s32); bus32.shift_direction_i = dr32;
            #1;
            check("rnd_n2", {30'b0, bus2.shifted_data_o}, ref_rot(2, {30'b0, d2}, s2, dr2));
            check("rnd_n8", {24'b0, bus8.shifted_data_o}, ref_rot(8, {24'b0, d8}, s8, dr8));
            check("rnd_n16", {16'b0, bus16.shifted_data_o}, ref_rot(16, {16'b0, d16}, s16, dr16));
            check("rnd_n32", bus32.shifted_data_o, ref_rot(32, d32, s32, dr32));
            check("pop_n2", 32'($countones(bus2.shifted_data_o)), 32'($countones(d2)));
            check("pop_n8", 32'($countones(bus8.shifted_data_o)), 32'($countones(d8)));
            check("pop_n16", 32'($countones(bus16.shifted_data_o)), 32'($countones(d16)));
            check("pop_n32", 32'($countones(bus32.shifted_data_o)), 32'($countones(d32)));
        end

        // Random traffic through the registered path.
        @(posedge clk);
        #1;
        reset_model();
        hist.push_back('{v: 1'b0, d: 8'h00});
        while (hist.size() > LAT) void'(hist.pop_front());
        exp_q = bus8.shifted_data_q_o;
        check("q_pre_random", {24'b0, bus8.shifted_data_q_o}, {24'b0, ref_rot_last8()});
        for (int i = 0; i < 200; i++) begin
            step8(8'($urandom), 3'($urandom), 1'($urandom), $urandom_range(3, 0) != 0);
        end

        // Back-to-back valid for 4 cycles, then idle with changing operands.
        for (int i = 0; i < 4; i++) begin
            last_in = 8'($urandom);
            step8(last_in, 3'(i + 1), 1'(i), 1'b1);
        end
        last_exp = ref_rot(8, {24'b0, last_in}, 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step8(8'($urandom), 3'($urandom), 1'($urandom), 1'b0);
        end
        check("hold_after_burst", {24'b0, bus8.shifted_data_q_o}, last_exp);

        // Asynchronous reset with valid_o high, then first capture after release.
        for (int i = 0; i < LAT; i++) step8(8'h3C, 3'd2, 1'b0, 1'b1);
        check("valid_before_rst", {31'b0, bus8.valid_o}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_q", {24'b0, bus8.shifted_data_q_o}, 32'h0);
        check("async_rst_valid", {31'b0, bus8.valid_o}, 32'h0);
        reset_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < LAT; i++) step8(8'hA5, 3'd3, 1'b1, 1'b1);
        check("post_rst_q", {24'b0, bus8.shifted_data_q_o}, 32'h2D);
        check("post_rst_valid", {31'b0, bus8.valid_o}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Expected registered output before the random run: the last value the model holds (reset = 0,
    // nothing was ever validated since the last reset, so the register must still read 0).
    function automatic logic [31:0] ref_rot_last8();
        return 32'h0;
    endfunction
endmodule
